// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request per instruction,
// holds the fetched word for decode and applies branch/jump redirects on accept.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / redirect_count outputs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  input  logic [25:0] jtarget,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count,
`endif
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        accept;

  assign imem_addr = pc;
  assign pcplus4   = pc + 32'd4;
  assign accept    = (state == S_HOLD) && instr_ready;

  // Jump outranks a taken branch; signimm is a word offset.
  always_comb begin
    branch_target = pcplus4 + {signimm[29:0], 2'b00};
    jump_target   = {pcplus4[31:28], jtarget, 2'b00};
    next_pc       = pcplus4;
    if (jump)       next_pc = jump_target;
    else if (pcsrc) next_pc = branch_target;
  end

  // NOTE: state registers use non-blocking assignments so every branch below
  // reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          imem_req <= 1'b0;
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_HOLD;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (accept) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
      if (jump || pcsrc) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed redirect/timeout/reset
// scenarios followed by randomized fetches against a PC reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [25:0] jtarget;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  int model_accepts;
  int model_redirects;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .pc            (pc),
    .pcplus4       (pcplus4),
    .pcsrc         (pcsrc),
    .jump          (jump),
    .signimm       (signimm),
    .jtarget       (jtarget),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count),
`endif
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural next-PC rule, written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j, input logic p,
                                             input logic [31:0] si, input logic [25:0] jt);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return {seq[31:28], jt, 2'b00};
    if (p) return seq + si * 32'd4;
    return seq;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    check("rst_pc", pc, RESET_PC);
    reset = 1'b0;
    exp_pc = RESET_PC;
    model_accepts = 0;
    model_redirects = 0;
  endtask

  // Bounded wait for the request pulse, then check its address.
  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1'b1);
    check("req_addr", imem_addr, exp_pc);
  endtask

  // Called in a WAIT cycle: stall lat cycles, respond, hold, then accept.
  task automatic serve_after_req(input int lat, input logic [31:0] data, input int hold,
                                 input logic j, input logic p, input logic [31:0] si,
                                 input logic [25:0] jt);
    logic [31:0] held_instr;
    for (int i = 0; i < lat; i++) begin
      imem_rvalid = 1'b0;
      instr_ready = 1'($urandom);
      pcsrc = 1'($urandom);
      jump = 1'($urandom);
      @(negedge clk);
      if (i == 0) check("req_one_cycle", imem_req, 1'b0);
    end
    imem_rvalid = 1'b1;
    imem_rdata = data;
    instr_ready = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    check("hold_valid", instr_valid, 1'b1);
    check("hold_instr", instr, data);
    check("hold_pc", pc, exp_pc);
    check("hold_pcplus4", pcplus4, exp_pc + 32'd4);
    held_instr = instr;
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      pcsrc = 1'($urandom);
      jump = 1'($urandom);
      signimm = $urandom;
      jtarget = 26'($urandom);
      @(negedge clk);
      check("stall_instr", instr, held_instr);
      check("stall_pc", pc, exp_pc);
      check("stall_valid", instr_valid, 1'b1);
      check("stall_req", imem_req, 1'b0);
    end
    instr_ready = 1'b1;
    jump = j;
    pcsrc = p;
    signimm = si;
    jtarget = jt;
    exp_pc = model_next(exp_pc, j, p, si, jt);
    model_accepts++;
    if (j || p) model_redirects++;
    @(negedge clk);
    instr_ready = 1'b0;
    jump = 1'($urandom);
    pcsrc = 1'($urandom);
    check("accept_valid", instr_valid, 1'b0);
    check("accept_pc", pc, exp_pc);
  endtask

  task automatic serve(input int lat, input logic [31:0] data, input int hold, input logic j,
                       input logic p, input logic [31:0] si, input logic [25:0] jt);
    wait_req();
    serve_after_req(lat, data, hold, j, p, si, jt);
  endtask

  initial begin
    reset = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    signimm = '0;
    jtarget = '0;
    exp_pc = RESET_PC;
    model_accepts = 0;
    model_redirects = 0;

    @(negedge clk);
    check("por_valid", instr_valid, 1'b0);
    check("por_req", imem_req, 1'b0);
    check("por_err", fetch_err, 1'b0);
    check("por_instr", instr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("first_req", imem_req, 1'b1);

    // First word, 5-cycle stall, sequential accept.
    serve(1, 32'h2008_0005, 5, 1'b0, 1'b0, 32'h0, 26'h0);
    // Jump to 0x10, backward branch to 0x08, jump to 0x10, forward branch to 0x1C.
    serve(0, $urandom, 0, 1'b1, 1'b0, 32'h0, 26'h000_0004);
    check("pc_jump_0x10", exp_pc, 32'h0000_0010);
    serve(2, $urandom, 1, 1'b0, 1'b1, 32'hFFFF_FFFD, 26'h0);
    serve(0, $urandom, 0, 1'b1, 1'b0, 32'h0, 26'h000_0004);
    serve(0, $urandom, 0, 1'b0, 1'b1, 32'h0000_0002, 26'h0);
    wait_req();
    check("branch_fwd_addr", imem_addr, 32'h0000_001C);
    serve_after_req(0, $urandom, 0, 1'b0, 1'b1, 32'h0400_0008, 26'h0);
    // At 0x1000_0040: jump beats branch.
    wait_req();
    check("far_addr", imem_addr, 32'h1000_0040);
    serve_after_req(TIMEOUT - 1, $urandom, 0, 1'b1, 1'b1, 32'h0000_0100, 26'h000_0010);
    wait_req();
    check("jump_wins_addr", imem_addr, 32'h1000_0040);
    // Branch to the top word so pcplus4 wraps, then fall through to 0.
    serve_after_req(0, $urandom, 0, 1'b0, 1'b1, (32'hFFFF_FFFC - (exp_pc + 32'd4)) >> 2, 26'h0);
    wait_req();
    check("top_pc", imem_addr, 32'hFFFF_FFFC);
    serve_after_req(1, $urandom, 0, 1'b0, 1'b0, 32'h0, 26'h0);
    wait_req();
    check("wrap_addr", imem_addr, 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", fetch_count, 32'(model_accepts));
    check("perf_redirect", redirect_count, 32'(model_redirects));
`endif

    // Timeout: no response for TIMEOUT WAIT cycles.
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("wait_no_err", fetch_err, 1'b0);
    end
    @(negedge clk);
    check("timeout_err", fetch_err, 1'b1);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_req", imem_req, 1'b0);
      check("err_valid", instr_valid, 1'b0);
      check("err_sticky", fetch_err, 1'b1);
    end
    imem_rvalid = 1'b0;
    do_reset();
    serve(0, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, 26'h0);

    // Reset during WAIT with rvalid high through reset and the first FETCH cycle.
    wait_req();
    @(negedge clk);
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_req", imem_req, 1'b0);
    reset = 1'b0;
    exp_pc = RESET_PC;
    model_accepts = 0;
    model_redirects = 0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("refetch_req", imem_req, 1'b1);
    check("refetch_addr", imem_addr, RESET_PC);
    check("refetch_valid", instr_valid, 1'b0);
    @(negedge clk);
    check("dropped_resp", instr_valid, 1'b0);
    serve_after_req(0, 32'hCAFE_0001, 1, 1'b0, 1'b0, 32'h0, 26'h0);

    // Randomized fetches.
    for (int k = 0; k < 40; k++) begin
      serve(int'($urandom_range(TIMEOUT - 1, 0)), $urandom, int'($urandom_range(3, 0)),
            1'($urandom), 1'($urandom), $urandom, 26'($urandom));
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_end", fetch_count, 32'(model_accepts));
    check("perf_redirect_end", redirect_count, 32'(model_redirects));
`endif
    check("end_no_err", fetch_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
